// File: rtl/openhmc_axi_tx_flit_packer_pkg.sv
// Shared types and TUSER field layout for the TX flit packer.
package openhmc_pkg;

  localparam int unsigned FLIT_W = 128;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic              hdr;
    logic              tail;
  } flit_t;

  // Assembly register occupancy: filling, or holding a complete beat
  // that is waiting for the output register.
  typedef enum logic {
    ASM_FILL = 1'b0,
    ASM_FULL = 1'b1
  } asm_state_e;

  function automatic int unsigned tuser_valid_lsb(input int unsigned fpw);
    return 0;
  endfunction

  function automatic int unsigned tuser_hdr_lsb(input int unsigned fpw);
    return fpw;
  endfunction

  function automatic int unsigned tuser_tail_lsb(input int unsigned fpw);
    return 2 * fpw;
  endfunction

endpackage

// File: rtl/openhmc_flit_slot_reg.sv
// FPW-slot assembly register: indexed slot write plus whole-register clear.
module openhmc_flit_slot_reg
  import openhmc_pkg::*;
#(
  parameter int unsigned FPW     = 4,
  parameter int unsigned LOG_FPW = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [LOG_FPW-1:0]      widx_i,
  input  flit_t                   flit_i,
  output logic [FPW*FLIT_W-1:0]   data_o,
  output logic [FPW-1:0]          valid_o,
  output logic [FPW-1:0]          hdr_o,
  output logic [FPW-1:0]          tail_o
);

  logic [FPW*FLIT_W-1:0] data_q;
  logic [FPW-1:0]        valid_q;
  logic [FPW-1:0]        hdr_q;
  logic [FPW-1:0]        tail_q;

  // Clear empties every slot; a write in the same cycle lands on top of
  // the cleared register so a new beat can start while the old one leaves.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= '0;
      hdr_q   <= '0;
      tail_q  <= '0;
    end else begin
      if (clr_i) begin
        data_q  <= '0;
        valid_q <= '0;
        hdr_q   <= '0;
        tail_q  <= '0;
      end
      if (we_i) begin
        data_q[widx_i*FLIT_W +: FLIT_W] <= flit_i.data;
        valid_q[widx_i]                 <= 1'b1;
        hdr_q[widx_i]                   <= flit_i.hdr;
        tail_q[widx_i]                  <= flit_i.tail;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign hdr_o   = hdr_q;
  assign tail_o  = tail_q;

endmodule

// File: rtl/openhmc_axi_tx_flit_packer.sv
// Packs 128-bit flits into FPW-wide AXI4-Stream beats with TUSER masks,
// holding each beat until accepted and flushing partial beats when idle.
module openhmc_axi_tx_flit_packer
  import openhmc_pkg::*;
#(
  parameter int unsigned FPW            = 4,
  parameter int unsigned LOG_FPW        = 2,
  parameter int unsigned DWIDTH         = FPW*128,
  parameter int unsigned NUM_DATA_BYTES = FPW*16,
  parameter int unsigned FLUSH_CYCLES   = 8
) (
  input  logic                      clk_hmc,
  input  logic                      res_n_hmc,
  input  logic                      flit_valid,
  output logic                      flit_ready,
  input  logic [127:0]              flit_data,
  input  logic                      flit_hdr,
  input  logic                      flit_tail,
  output logic                      s_axis_tx_TVALID,
  input  logic                      s_axis_tx_TREADY,
  output logic [DWIDTH-1:0]         s_axis_tx_TDATA,
  output logic [NUM_DATA_BYTES-1:0] s_axis_tx_TUSER
);

  localparam logic [LOG_FPW-1:0] LAST_SLOT = LOG_FPW'(FPW - 1);
  localparam logic [7:0]         FLUSH_LIM = 8'(FLUSH_CYCLES);

  asm_state_e                asm_st_q, asm_st_d;
  logic [LOG_FPW-1:0]        slot_cnt_q, slot_cnt_d;
  logic [7:0]                idle_cnt_q, idle_cnt_d;
  logic                      tvalid_q, tvalid_d;
  logic [DWIDTH-1:0]         tdata_q, tdata_d;
  logic [NUM_DATA_BYTES-1:0] tuser_q, tuser_d;

  logic [FPW*FLIT_W-1:0]     asm_data;
  logic [FPW-1:0]            asm_valid, asm_hdr, asm_tail;
  logic [NUM_DATA_BYTES-1:0] asm_user;

  logic  accept, out_free, flush_pend, move;
  flit_t flit_in;

  assign flit_in    = '{data: flit_data, hdr: flit_hdr, tail: flit_tail};
  assign out_free   = !tvalid_q || s_axis_tx_TREADY;
  assign flush_pend = (slot_cnt_q != '0) && (idle_cnt_q == FLUSH_LIM);
  assign move       = ((asm_st_q == ASM_FULL) || flush_pend) && out_free;
  // Held off in the flush cycle so the arriving flit starts the next beat.
  assign flit_ready = res_n_hmc
                      && !((asm_st_q == ASM_FULL) && tvalid_q && !s_axis_tx_TREADY)
                      && !flush_pend;
  assign accept     = flit_valid && flit_ready;

  openhmc_flit_slot_reg #(
    .FPW     (FPW),
    .LOG_FPW (LOG_FPW)
  ) u_slots (
    .clk_i   (clk_hmc),
    .rst_n_i (res_n_hmc),
    .clr_i   (move),
    .we_i    (accept),
    .widx_i  (slot_cnt_q),
    .flit_i  (flit_in),
    .data_o  (asm_data),
    .valid_o (asm_valid),
    .hdr_o   (asm_hdr),
    .tail_o  (asm_tail)
  );

  // Lay the assembly masks out into the TUSER field positions.
  always_comb begin
    asm_user = '0;
    asm_user[tuser_valid_lsb(FPW) +: FPW] = asm_valid;
    asm_user[tuser_hdr_lsb(FPW)   +: FPW] = asm_hdr;
    asm_user[tuser_tail_lsb(FPW)  +: FPW] = asm_tail;
  end

  // Next-state decode for slot pointer, idle timer, assembly state and output beat.
  always_comb begin
    asm_st_d   = asm_st_q;
    slot_cnt_d = slot_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;

    if (accept) begin
      slot_cnt_d = (slot_cnt_q == LAST_SLOT) ? '0 : slot_cnt_q + 1'b1;
    end else if (move) begin
      slot_cnt_d = '0;
    end

    if (accept && (slot_cnt_q == LAST_SLOT)) begin
      asm_st_d = ASM_FULL;
    end else if (move) begin
      asm_st_d = ASM_FILL;
    end

    if (accept || move) begin
      idle_cnt_d = '0;
    end else if ((slot_cnt_q != '0) && (idle_cnt_q != FLUSH_LIM)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (move) begin
      tvalid_d = 1'b1;
      tdata_d  = asm_data;
      tuser_d  = asm_user;
    end else if (s_axis_tx_TREADY) begin
      tvalid_d = 1'b0;
    end
  end

  // Control and output register state.
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      asm_st_q   <= ASM_FILL;
      slot_cnt_q <= '0;
      idle_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= '0;
    end else begin
      asm_st_q   <= asm_st_d;
      slot_cnt_q <= slot_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
    end
  end

  assign s_axis_tx_TVALID = tvalid_q;
  assign s_axis_tx_TDATA  = tdata_q;
  assign s_axis_tx_TUSER  = tuser_q;

endmodule
